// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and the load/store unit.
// Optional `STARVE_GUARD_EN caps consecutive LSU grants so a waiting fetch is eventually served.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT_CYC  = 1023,
    parameter int MAX_LS_BURST = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    input  logic                i_if_kill,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_ack,
    output logic                o_if_stall,
    input  logic                i_ls_req,
    input  logic                i_ls_wren,
    input  logic [ADDR_W-1:0]   i_ls_addr,
    input  logic [DATA_W-1:0]   i_ls_wdata,
    input  logic [DATA_W/8-1:0] i_ls_bmask,
    output logic [DATA_W-1:0]   o_ls_rdata,
    output logic                o_ls_ack,
    output logic                o_ls_stall,
    output logic                o_mem_req,
    output logic                o_mem_wren,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_bmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_ack,
    output logic                o_timeout
);

    localparam int BM_W = DATA_W / 8;
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        LS_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_r;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic                owner_ls_r;
    logic                kill_seen_r;
    logic                if_ack_r;
    logic                ls_ack_r;
    logic [DATA_W-1:0]   if_rdata_r;
    logic [DATA_W-1:0]   ls_rdata_r;
    logic                mem_req_r;
    logic                mem_wren_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [BM_W-1:0]     mem_bmask_r;
    logic                timeout_r;

    logic                if_force_s;
    logic                ls_grant_s;
    logic                if_grant_s;
    logic                wait_done_s;
    logic                finish_s;
    logic                if_killed_s;
    logic [DATA_W-1:0]   rsp_data_s;

`ifdef STARVE_GUARD_EN
    localparam int BURST_W = $clog2(MAX_LS_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_LS_BURST);

    logic [BURST_W-1:0]  burst_r;

    // Counts consecutive LSU grants, saturating; any fetch grant restarts the run.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            burst_r <= '0;
        end else if (state_r == IDLE && ls_grant_s) begin
            if (burst_r != BURST_MAX) begin
                burst_r <= burst_r + BURST_W'(1);
            end
        end else if (state_r == IDLE && if_grant_s) begin
            burst_r <= '0;
        end
    end

    assign if_force_s = i_if_req & (burst_r == BURST_MAX);
`else
    logic unused_burst_cfg_s;
    // Burst limit has no effect under strict LSU priority.
    assign unused_burst_cfg_s = (MAX_LS_BURST > 0);
    assign if_force_s = 1'b0;
`endif

    // Grant decision: LSU is the older instruction and wins unless the starvation guard forces IF.
    always_comb begin
        ls_grant_s = 1'b0;
        if_grant_s = 1'b0;
        if (i_ls_req && !if_force_s) begin
            ls_grant_s = 1'b1;
        end else if (i_if_req) begin
            if_grant_s = 1'b1;
        end else begin
            ls_grant_s = 1'b0;
            if_grant_s = 1'b0;
        end
    end

    // Completion condition and the data returned to the owner (zero on timeout).
    always_comb begin
        rsp_data_s = '0;
        if (i_mem_ack) begin
            rsp_data_s = i_mem_rdata;
        end else begin
            rsp_data_s = '0;
        end
    end

    assign wait_done_s = (wait_cnt_r == WAIT_LAST);
    assign finish_s    = i_mem_ack | wait_done_s;
    assign if_killed_s = kill_seen_r | i_if_kill;

    // Main sequencer: grant, hold the request until ack or timeout, then a one-cycle response.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= IDLE;
            wait_cnt_r  <= '0;
            owner_ls_r  <= 1'b0;
            kill_seen_r <= 1'b0;
            if_ack_r    <= 1'b0;
            ls_ack_r    <= 1'b0;
            if_rdata_r  <= '0;
            ls_rdata_r  <= '0;
            mem_req_r   <= 1'b0;
            mem_wren_r  <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_bmask_r <= '0;
            timeout_r   <= 1'b0;
        end else begin
            if_ack_r <= 1'b0;
            ls_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    wait_cnt_r  <= '0;
                    kill_seen_r <= 1'b0;
                    if (ls_grant_s) begin
                        mem_req_r   <= 1'b1;
                        mem_wren_r  <= i_ls_wren;
                        mem_addr_r  <= i_ls_addr;
                        mem_wdata_r <= i_ls_wdata;
                        mem_bmask_r <= i_ls_bmask;
                        owner_ls_r  <= 1'b1;
                        state_r     <= LS_WAIT;
                    end else if (if_grant_s) begin
                        mem_req_r   <= 1'b1;
                        mem_wren_r  <= 1'b0;
                        mem_addr_r  <= i_if_addr;
                        mem_wdata_r <= '0;
                        mem_bmask_r <= '1;
                        owner_ls_r  <= 1'b0;
                        state_r     <= IF_WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IF_WAIT, LS_WAIT: begin
                    if (state_r == IF_WAIT && i_if_kill) begin
                        kill_seen_r <= 1'b1;
                    end
                    if (finish_s) begin
                        mem_req_r  <= 1'b0;
                        mem_wren_r <= 1'b0;
                        state_r    <= RESP;
                        if (!i_mem_ack) begin
                            timeout_r <= 1'b1;
                        end
                        if (owner_ls_r) begin
                            ls_ack_r <= 1'b1;
                            // Stores leave the last load data untouched.
                            if (!mem_wren_r) begin
                                ls_rdata_r <= rsp_data_s;
                            end
                        end else begin
                            if_ack_r <= ~if_killed_s;
                            if (!if_killed_s) begin
                                if_rdata_r <= rsp_data_s;
                            end
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_if_rdata  = if_rdata_r;
    // A redirect arriving in the response cycle itself must still swallow the fetch ack.
    assign o_if_ack    = if_ack_r & ~i_if_kill;
    assign o_if_stall  = i_if_req & ~o_if_ack;
    assign o_ls_rdata  = ls_rdata_r;
    assign o_ls_ack    = ls_ack_r;
    assign o_ls_stall  = i_ls_req & ~o_ls_ack;
    assign o_mem_req   = mem_req_r;
    assign o_mem_wren  = mem_wren_r;
    assign o_mem_addr  = mem_addr_r;
    assign o_mem_wdata = mem_wdata_r;
    assign o_mem_bmask = mem_bmask_r;
    assign o_timeout   = timeout_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand-written kill, timeout, reset and burst sequences.
// A reactive memory model checks o_mem_* per request cycle; a response scoreboard checks every ack.
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_if_req, i_if_kill, i_ls_req, i_ls_wren, i_mem_ack;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_bmask;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic        o_if_ack, o_if_stall, o_ls_ack, o_ls_stall, o_mem_req, o_mem_wren, o_timeout;
    logic [3:0]  o_mem_bmask;

    typedef struct {
        bit          is_ls;
        bit          wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        int          delay;
        logic [31:0] exp_rdata;
    } vec_t;
    typedef struct {
        bit          wren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
    } mem_exp_t;
    typedef struct {
        bit          is_ls;
        logic [31:0] data;
    } resp_t;

    mem_exp_t mem_q[$];
    resp_t    resp_q[$];
    vec_t     vecs[6];
    int       vectors = 0;
    int       miscompares = 0;
    int       mem_delay = 0;
    bit       mem_mute = 1'b0;
    bit       stray_ack = 1'b0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8), .MAX_LS_BURST(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_kill(i_if_kill),
        .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack), .o_if_stall(o_if_stall),
        .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask),
        .o_ls_rdata(o_ls_rdata), .o_ls_ack(o_ls_ack), .o_ls_stall(o_ls_stall),
        .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0000_0513;
        return a ^ 32'h1234_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name, input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, msg);
    endtask

    task automatic expect_txn(input bit is_ls, input bit wren, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] bmask,
                              input bit want_resp, input logic [31:0] data);
        mem_exp_t m;
        resp_t    r;
        m.wren = wren; m.addr = addr; m.wdata = wdata; m.bmask = bmask;
        mem_q.push_back(m);
        if (want_resp) begin
            r.is_ls = is_ls; r.data = data;
            resp_q.push_back(r);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, 32'({o_mem_req, o_mem_wren, o_if_ack, o_ls_ack, o_timeout, o_if_stall, o_ls_stall}), 32'h0);
        chk({name, "_addr"}, o_mem_addr, 32'h0);
        chk({name, "_wdata"}, o_mem_wdata, 32'h0);
        chk({name, "_bmask"}, 32'(o_mem_bmask), 32'h0);
        chk({name, "_if_rdata"}, o_if_rdata, 32'h0);
        chk({name, "_ls_rdata"}, o_ls_rdata, 32'h0);
    endtask

    task automatic wait_ack(input bit is_ls);
        int n;
        bit got;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(negedge i_clk);
            n++;
            got = is_ls ? o_ls_ack : o_if_ack;
            if (is_ls) chk("ls_stall", 32'(o_ls_stall), 32'(!o_ls_ack));
            else       chk("if_stall", 32'(o_if_stall), 32'(!o_if_ack));
        end
        if (!got) fail_msg("ack_wait", "no ack within 200 cycles");
    endtask

    task automatic ls_txn(input bit wren, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] bmask);
        @(posedge i_clk); #1;
        i_ls_req = 1'b1; i_ls_wren = wren; i_ls_addr = addr; i_ls_wdata = wdata; i_ls_bmask = bmask;
        wait_ack(1'b1);
        @(posedge i_clk); #1;
        i_ls_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] addr);
        @(posedge i_clk); #1;
        i_if_req = 1'b1; i_if_addr = addr;
        wait_ack(1'b0);
        @(posedge i_clk); #1;
        i_if_req = 1'b0;
    endtask

    task automatic ls_stream(input int n, input logic [31:0] base);
        @(posedge i_clk); #1;
        i_ls_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            i_ls_wren = 1'b0; i_ls_addr = base + 32'(4 * i); i_ls_bmask = 4'hF;
            wait_ack(1'b1);
            @(posedge i_clk); #1;
        end
        i_ls_req = 1'b0;
    endtask

    // Memory model: checks the held request fields every cycle and acks after mem_delay cycles.
    initial begin
        int       cnt;
        bit       active;
        mem_exp_t cur;
        i_mem_ack = 1'b0; i_mem_rdata = 32'h0; cnt = 0; active = 1'b0;
        cur.wren = 1'b0; cur.addr = 32'h0; cur.wdata = 32'h0; cur.bmask = 4'h0;
        forever begin
            @(negedge i_clk);
            i_mem_ack = 1'b0;
            if (stray_ack) begin
                i_mem_ack = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
            end else if (o_mem_req) begin
                if (!active) begin
                    active = 1'b1; cnt = 0;
                    if (mem_q.size() == 0) fail_msg("mem_unexpected", "request with no expected transaction");
                    else cur = mem_q.pop_front();
                end
                chk("mem_wren", 32'(o_mem_wren), 32'(cur.wren));
                chk("mem_addr", o_mem_addr, cur.addr);
                chk("mem_bmask", 32'(o_mem_bmask), 32'(cur.bmask));
                if (cur.wren) chk("mem_wdata", o_mem_wdata, cur.wdata);
                if (!mem_mute && cnt == mem_delay) begin
                    i_mem_ack = 1'b1; i_mem_rdata = mem_fn(o_mem_addr);
                end
                cnt++;
            end else begin
                active = 1'b0;
            end
        end
    end

    // Response scoreboard: every ack must match the next expected owner and data.
    initial begin
        resp_t r;
        forever begin
            @(negedge i_clk);
            if (o_if_ack && o_ls_ack) begin
                fail_msg("ack_overlap", "both acks high");
            end else if (o_if_ack || o_ls_ack) begin
                if (resp_q.size() == 0) begin
                    fail_msg("ack_unexpected", $sformatf("if_ack=%0b ls_ack=%0b", o_if_ack, o_ls_ack));
                end else begin
                    r = resp_q.pop_front();
                    chk("ack_side", 32'(o_ls_ack), 32'(r.is_ls));
                    chk(r.is_ls ? "ls_rdata" : "if_rdata", r.is_ls ? o_ls_rdata : o_if_rdata, r.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 2, 32'h0000_0513};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h1234_0200};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 4'hC, 1, 32'h1234_0200};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0014, 32'h0, 4'hF, 3, 32'h1234_0014};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 5, 32'hEDCB_FFFC};
        vecs[5] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'hF, 7, 32'h9234_0000};

        i_reset = 1'b0; i_if_req = 1'b0; i_if_kill = 1'b0; i_if_addr = 32'h0;
        i_ls_req = 1'b0; i_ls_wren = 1'b0; i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_ls_bmask = 4'h0;
        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk); #1;
        i_reset = 1'b1;

        // Main table; the delay-7 entry acks in the last cycle before a timeout would fire.
        foreach (vecs[i]) begin
            mem_delay = vecs[i].delay;
            expect_txn(vecs[i].is_ls, vecs[i].wren, vecs[i].addr, vecs[i].wdata,
                       vecs[i].is_ls ? vecs[i].bmask : 4'hF, 1'b1, vecs[i].exp_rdata);
            if (vecs[i].is_ls) ls_txn(vecs[i].wren, vecs[i].addr, vecs[i].wdata, vecs[i].bmask);
            else               if_txn(vecs[i].addr);
        end
        chk("no_timeout_yet", 32'(o_timeout), 32'h0);

        // Collision: store wins, fetch follows.
        mem_delay = 1;
        expect_txn(1'b1, 1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 4'h3, 1'b1, 32'hEDCB_FFFC);
        expect_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b1, 32'h1234_0040);
        fork
            ls_txn(1'b1, 32'h0000_7000, 32'hDEAD_BEEF, 4'h3);
            if_txn(32'h0000_0040);
        join

        // Kill during IF_WAIT: memory completes, no ack; the next fetch acks normally.
        mem_delay = 4;
        expect_txn(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'hF, 1'b0, 32'h0);
        @(posedge i_clk); #1;
        i_if_req = 1'b1; i_if_addr = 32'h0000_0080;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!o_mem_req && n < 20);
        if (!o_mem_req) fail_msg("kill_req", "fetch never reached memory");
        @(posedge i_clk); #1;
        i_if_kill = 1'b1;
        @(posedge i_clk); #1;
        i_if_kill = 1'b0; i_if_req = 1'b0;
        repeat (10) @(negedge i_clk);
        chk("kill_idle_req", 32'(o_mem_req), 32'h0);
        chk("kill_if_stall", 32'(o_if_stall), 32'h0);
        mem_delay = 0;
        expect_txn(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1, 32'h1234_0100);
        if_txn(32'h0000_0100);

        // Timeout on a load: request held exactly 8 cycles, ack with zero data, sticky flag.
        mem_mute = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF, 1'b1, 32'h0);
        fork
            ls_txn(1'b0, 32'h0000_0900, 32'h0, 4'hF);
            begin
                n = 0;
                do begin @(negedge i_clk); n++; end while (!o_mem_req && n < 20);
                c = 0;
                while (o_mem_req && c < 50) begin c++; @(negedge i_clk); end
                chk("timeout_req_cycles", 32'(c), 32'd8);
            end
        join
        chk("timeout_flag", 32'(o_timeout), 32'h1);
        mem_mute = 1'b0;
        expect_txn(1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF, 1'b1, 32'h1234_0A00);
        ls_txn(1'b0, 32'h0000_0A00, 32'h0, 4'hF);
        chk("timeout_sticky", 32'(o_timeout), 32'h1);

        // Reset during LS_WAIT, then a stray memory ack.
        mem_mute = 1'b1;
        expect_txn(1'b1, 1'b0, 32'h0000_0B00, 32'h0, 4'hF, 1'b0, 32'h0);
        @(posedge i_clk); #1;
        i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h0000_0B00; i_ls_bmask = 4'hF;
        n = 0;
        do begin @(negedge i_clk); n++; end while (!o_mem_req && n < 20);
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_ls_req = 1'b0;
        #1;
        chk("rst_async_req", 32'(o_mem_req), 32'h0);
        @(negedge i_clk);
        check_all_zero("midrst");
        @(posedge i_clk); #1;
        i_reset = 1'b1; mem_mute = 1'b0; stray_ack = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 stray_ack = 1'b0;
        repeat (2) @(negedge i_clk);
        check_all_zero("stray_ack");

        // Six back-to-back LSU loads with a fetch pending from the start.
        mem_delay = 0;
`ifdef STARVE_GUARD_EN
        for (int i = 0; i < 4; i++)
            expect_txn(1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b1, 32'h1234_3000 + 32'(4 * i));
        expect_txn(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1'b1, 32'h1234_0500);
        for (int i = 4; i < 6; i++)
            expect_txn(1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b1, 32'h1234_3000 + 32'(4 * i));
`else
        for (int i = 0; i < 6; i++)
            expect_txn(1'b1, 1'b0, 32'h0000_3000 + 32'(4 * i), 32'h0, 4'hF, 1'b1, 32'h1234_3000 + 32'(4 * i));
        expect_txn(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1'b1, 32'h1234_0500);
`endif
        fork
            ls_stream(6, 32'h0000_3000);
            if_txn(32'h0000_0500);
        join

        repeat (4) @(negedge i_clk);
        chk("mem_q_left", 32'(mem_q.size()), 32'h0);
        chk("resp_q_left", 32'(resp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port, variable-latency unified memory shared by the pipelined core's instruction fetch (IF) and load/store unit (LSU, MEM stage).
- Grants one requester at a time and holds the memory request stable until the memory acknowledges.
- Returns read data to the granted side, and drives per-side stall signals that the hazard unit folds into its PC, IF/ID and ID/EX stall terms.

Parameters:
- ADDR_W, 32, memory address width in bits.
- DATA_W, 32, data width in bits; byte-mask width is DATA_W/8.
- TIMEOUT_CYC, 1023, maximum wait cycles for i_mem_ack before the transaction is abandoned.
- MAX_LS_BURST, 4, consecutive LSU grants allowed before IF is forced; used only with STARVE_GUARD_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_if_req  in  1  fetch request; held until o_if_ack.
- i_if_addr  in  ADDR_W  fetch address (the PC).
- i_if_kill  in  1  fetch redirected (mispredict); the pending IF response is discarded.
- o_if_rdata  out  DATA_W  fetched instruction, valid with o_if_ack.
- o_if_ack  out  1  one-cycle completion pulse to IF.
- o_if_stall  out  1  i_if_req & ~o_if_ack.
- i_ls_req  in  1  LSU request; held until o_ls_ack.
- i_ls_wren  in  1  1 = store, 0 = load.
- i_ls_addr  in  ADDR_W  LSU address.
- i_ls_wdata  in  DATA_W  store data.
- i_ls_bmask  in  DATA_W/8  store byte enables.
- o_ls_rdata  out  DATA_W  load data, valid with o_ls_ack.
- o_ls_ack  out  1  one-cycle completion pulse to LSU.
- o_ls_stall  out  1  i_ls_req & ~o_ls_ack.
- o_mem_req  out  1  memory request; held until i_mem_ack.
- o_mem_wren  out  1  write strobe for the granted transaction.
- o_mem_addr  out  ADDR_W  latched address.
- o_mem_wdata  out  DATA_W  latched store data.
- o_mem_bmask  out  DATA_W/8  latched byte mask; all ones for IF reads.
- i_mem_rdata  in  DATA_W  memory read data, valid with i_mem_ack.
- i_mem_ack  in  1  memory completion, one cycle.
- o_timeout  out  1  sticky error flag; set on any timeout.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata, o_mem_addr and o_mem_wdata, and the wait and burst counters.
  - A reset mid-transaction drops o_mem_req immediately.
  - An i_mem_ack arriving after reset is ignored.
- FSM states: IDLE, IF_WAIT, LS_WAIT, RESP.
- IDLE:
  - If i_ls_req: latch the LSU fields into the mem registers and go to LS_WAIT.
  - Else if i_if_req: latch i_if_addr, set wren = 0 and bmask = all ones, and go to IF_WAIT.
  - Otherwise stay in IDLE.
  - o_mem_req is registered and asserts the cycle after the grant decision.
- IF_WAIT / LS_WAIT:
  - o_mem_req = 1 and all o_mem_* fields are held stable.
  - The wait counter increments each cycle.
  - On i_mem_ack: capture i_mem_rdata into the owner's rdata register, deassert o_mem_req, and go to RESP.
- RESP (one cycle):
  - Pulse the owner's ack.
  - For the IF owner, the ack is suppressed if i_if_kill was seen at any point during IF_WAIT or in RESP itself; the memory transaction always completes regardless.
  - Return to IDLE.
  - Minimum latency is therefore request → ack = 3 cycles when the memory acks in the first request cycle.
- Ack and data timing:
  - Acks are mutually exclusive.
  - rdata registers hold their last value between acks.
  - o_ls_rdata is not updated on stores.
- Timeout:
  - When the wait counter reaches TIMEOUT_CYC without i_mem_ack, drop o_mem_req, set o_timeout, load 0 into the owner's rdata, and go to RESP.
  - The owner's ack still pulses, so the pipeline never deadlocks.
  - o_timeout clears only on reset.
- i_mem_ack while in IDLE or RESP is ignored.
- Requests arriving during WAIT or RESP are queued implicitly: requesters hold their request and are arbitrated in the next IDLE cycle.
- Simultaneous i_if_req and i_ls_req in IDLE: LSU wins, since it is the older instruction.

Optional Feature:
- Macro: STARVE_GUARD_EN.
- When defined:
  - A burst counter counts consecutive LSU grants; it is reset to 0 by any IF grant.
  - When the count equals MAX_LS_BURST and i_if_req = 1, IF wins the next IDLE arbitration even if i_ls_req = 1.
  - The counter saturates at MAX_LS_BURST.
- When undefined: strict LSU priority, and no counter logic is synthesized.

Test Plan:
- IF-only fetch: i_if_addr = 0x0000_0010, memory acks 2 cycles after o_mem_req with 0x0000_0513 → o_mem_wren = 0, o_mem_bmask = 0xF, one o_if_ack pulse with o_if_rdata = 0x0000_0513, o_if_stall high until the ack cycle.
- Collision: i_if_req and i_ls_req (store, addr 0x0000_7000, wdata 0xDEAD_BEEF, bmask 0x3) assert in the same cycle → LSU is served first with the exact addr, data and mask on o_mem_*; IF is granted in the following IDLE; no ack overlap.
- Kill: i_if_kill pulses during IF_WAIT → memory transaction completes, no o_if_ack, FSM back to IDLE; a subsequent fetch to 0x0000_0100 acks normally.
- Timeout: TIMEOUT_CYC = 8, memory never acks a load → o_mem_req drops after 8 wait cycles, o_ls_ack pulses with o_ls_rdata = 0, o_timeout = 1 and stays 1 until reset.
- Reset mid-transaction: assert i_reset = 0 during LS_WAIT, then release and deliver a stray i_mem_ack → all outputs 0, no ack pulse, FSM in IDLE.
- STARVE_GUARD_EN with MAX_LS_BURST = 4: LSU requests continuously and IF also requests → IF is granted after exactly 4 LSU grants; with the macro undefined, IF is never granted while LSU requests.
